// File: rtl/sdr_capture_pkg.sv
// Shared definitions for the SDRAM capture writer: controller state encoding.
package sdr_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop lands on the same edge.
module sync_fifo #(
  parameter int DQ_WIDTH = 16,
  parameter int DEPTH    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DQ_WIDTH-1:0]        wdata,
  output logic [DQ_WIDTH-1:0]        rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DQ_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage is not reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sdram_capture_writer.sv
// Buffers sampled words in a FIFO and streams them to an SDRAM controller over a
// commit (next_wr_ack) / data-sample (wr_ack) handshake, one-shot or as a ring.
module sdram_capture_writer
  import sdr_capture_pkg::*;
#(
  parameter int DQ_WIDTH = 16,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W-1:0]   cfg_len,
  input  logic                cfg_ring,
  input  logic                in_valid,
  input  logic [DQ_WIDTH-1:0] in_data,
  output logic [ADDR_W-1:0]   addr,
  output logic                wr_req,
  input  logic                next_wr_ack,
  input  logic                wr_ack,
  output logic [DQ_WIDTH-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [ADDR_W-1:0]   words_written
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: wr_req is high while some buffered word has no commit yet. A cycle
  // with wr_req & next_wr_ack commits the word at addr; the controller samples the
  // oldest committed word on wr_data with wr_ack, which pops it from the FIFO.
  cap_state_t        state;
  cap_state_t        state_next;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] len_r;
  logic              ring_r;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] accepted;
  logic [ADDR_W-1:0] cfg_len_eff;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     pending;
  logic              fifo_full;
  logic              fifo_empty;
  logic              commit;
  logic              ack_ok;
  logic              room;
  logic              push;
  logic              drop;

  assign cfg_len_eff = (cfg_len == '0) ? ADDR_W'(1) : cfg_len;
  assign last_addr   = base_r + len_r - ADDR_W'(1);
  assign busy        = (state != IDLE);
  assign wr_req      = busy && (fifo_count > pending);
  assign commit      = next_wr_ack && wr_req;
  assign ack_ok      = wr_ack && (pending != '0) && !fifo_empty;
  assign room        = !fifo_full || ack_ok;
  assign push        = (state == RUN) && !start && in_valid && room;
  assign drop        = (state == RUN) && !start && in_valid && !room;

  sync_fifo #(
    .DQ_WIDTH (DQ_WIDTH),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .push  (push),
    .pop   (ack_ok),
    .wdata (in_data),
    .rdata (wr_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = IDLE;
      RUN:   if (!ring_r && push && (accepted + ADDR_W'(1) == len_r)) state_next = DRAIN;
      DRAIN: if (words_written == len_r) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (start) state_next = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      base_r        <= '0;
      len_r         <= ADDR_W'(1);
      ring_r        <= 1'b0;
      addr          <= '0;
      accepted      <= '0;
      pending       <= '0;
      words_written <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        base_r        <= cfg_base;
        len_r         <= cfg_len_eff;
        ring_r        <= cfg_ring;
        addr          <= cfg_base;
        accepted      <= '0;
        pending       <= '0;
        words_written <= '0;
        done          <= 1'b0;
        overflow      <= 1'b0;
      end else begin
        if (commit) addr <= (addr == last_addr) ? base_r : addr + ADDR_W'(1);
        if (push) accepted <= accepted + ADDR_W'(1);
        if (drop) overflow <= 1'b1;
        pending <= pending + CW'(commit) - CW'(ack_ok);
        if (ack_ok) words_written <= words_written + ADDR_W'(1);
        if (state == DRAIN && state_next == IDLE) done <= 1'b1;
      end
    end
  end

  // A data-sample strobe with no committed write behind it is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_ack && !ack_ok) $warning("stray wr_ack ignored: no write outstanding");
  end

endmodule
